// File: rtl/enc_cnt_mc_if.sv
// Capture bus of the multi-channel encoder counter: arm/index/A inputs,
// per-channel acknowledge, and the capture/status outputs.
interface enc_cnt_mc_if #(
  parameter int P_CNT_W = 64,
  parameter int P_CH    = 4
);
  logic                      I_ARM;
  logic                      I_Z;
  logic [P_CH-1:0]           I_A;
  logic [P_CH-1:0]           I_ACK;
  logic [P_CH*P_CNT_W-1:0]   O_CNT;
  logic [P_CH-1:0]           O_VALID;
  logic [P_CH-1:0]           O_LOST;
  logic [P_CNT_W-1:0]        O_TIME;
  logic                      O_OVERFLOW;
  logic                      O_ACTIVE;

  // master: readout/control side; slave: the counter itself
  modport master (
    output I_ARM, I_Z, I_A, I_ACK,
    input  O_CNT, O_VALID, O_LOST, O_TIME, O_OVERFLOW, O_ACTIVE
  );
  modport slave (
    input  I_ARM, I_Z, I_A, I_ACK,
    output O_CNT, O_VALID, O_LOST, O_TIME, O_OVERFLOW, O_ACTIVE
  );
endinterface

// File: rtl/enc_cnt_mc.sv
// Multi-channel encoder capture: time base started by the first index edge
// after arming, per-channel A-edge captures with valid/ack and sticky flags.
module enc_cnt_mc #(
  parameter int P_CNT_W = 64,
  parameter int P_CH    = 4,
  parameter int P_SYNC  = 2,
  parameter int P_WRAP  = 1
) (
  input  logic          CLK,
  input  logic          I_RST,
  enc_cnt_mc_if.slave   bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_Z, ST_RUN} state_t;

  localparam logic [P_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [P_CNT_W-1:0] CNT_ONE = {{(P_CNT_W-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [P_SYNC-1:0]       z_sync_q;
  logic                    z_prev_q;
  logic [P_CH-1:0]         a_sync_q [P_SYNC];
  logic [P_CH-1:0]         a_prev_q;
  logic                    z_rise;
  logic [P_CH-1:0]         a_rise;
  logic                    run;
  logic                    clear;
  logic [P_CNT_W-1:0]      time_q, time_d;
  logic                    ovf_q, ovf_d;
  logic [P_CH*P_CNT_W-1:0] cnt_all;
  logic [P_CH-1:0]         valid_all;
  logic [P_CH-1:0]         lost_all;

  // Synchronisers and edge detectors keep running through disarm.
  always_ff @(posedge CLK) begin
    if (I_RST) begin
      z_sync_q <= '0;
      z_prev_q <= 1'b0;
      a_prev_q <= '0;
      for (int i = 0; i < P_SYNC; i++) a_sync_q[i] <= '0;
    end else begin
      z_sync_q    <= {z_sync_q[P_SYNC-2:0], bus.I_Z};
      z_prev_q    <= z_sync_q[P_SYNC-1];
      a_sync_q[0] <= bus.I_A;
      for (int i = 1; i < P_SYNC; i++) a_sync_q[i] <= a_sync_q[i-1];
      a_prev_q    <= a_sync_q[P_SYNC-1];
    end
  end

  assign z_rise = z_sync_q[P_SYNC-1] & ~z_prev_q;
  assign a_rise = a_sync_q[P_SYNC-1] & ~a_prev_q;
  assign clear  = ~bus.I_ARM;
  assign run    = (state_q == ST_RUN) && bus.I_ARM;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_WAIT_Z;
      ST_WAIT_Z: if (z_rise) state_d = ST_RUN;
      ST_RUN:    state_d = ST_RUN;
      default:   state_d = ST_IDLE;
    endcase
    if (!bus.I_ARM) state_d = ST_IDLE;
  end

  always_comb begin
    time_d = time_q;
    ovf_d  = ovf_q;
    if (clear) begin
      time_d = '0;
      ovf_d  = 1'b0;
    end else if (run) begin
      if (time_q == CNT_MAX) begin
        time_d = (P_WRAP != 0) ? '0 : CNT_MAX;
        ovf_d  = 1'b1;
      end else begin
        time_d = time_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (I_RST) begin
      state_q <= ST_IDLE;
      time_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      ovf_q   <= ovf_d;
    end
  end

  generate
    for (genvar gi = 0; gi < P_CH; gi++) begin : g_ch
      logic [P_CNT_W-1:0] cap_q, cap_d;
      logic               valid_q, valid_d;
      logic               lost_q, lost_d;

      // An unacked capture keeps the oldest value; the newer edge is flagged lost.
      always_comb begin
        cap_d   = cap_q;
        valid_d = valid_q;
        lost_d  = lost_q;
        if (clear) begin
          cap_d   = '0;
          valid_d = 1'b0;
          lost_d  = 1'b0;
        end else if (run) begin
          if (a_rise[gi]) begin
            if (!valid_q || bus.I_ACK[gi]) begin
              cap_d   = time_q;
              valid_d = 1'b1;
            end else begin
              lost_d  = 1'b1;
            end
          end else if (valid_q && bus.I_ACK[gi]) begin
            valid_d = 1'b0;
          end
        end
      end

      always_ff @(posedge CLK) begin
        if (I_RST) begin
          cap_q   <= '0;
          valid_q <= 1'b0;
          lost_q  <= 1'b0;
        end else begin
          cap_q   <= cap_d;
          valid_q <= valid_d;
          lost_q  <= lost_d;
        end
      end

      assign cnt_all[gi*P_CNT_W +: P_CNT_W] = cap_q;
      assign valid_all[gi]                  = valid_q;
      assign lost_all[gi]                   = lost_q;
    end
  endgenerate

  assign bus.O_CNT      = cnt_all;
  assign bus.O_VALID    = valid_all;
  assign bus.O_LOST     = lost_all;
  assign bus.O_TIME     = time_q;
  assign bus.O_OVERFLOW = ovf_q;
  assign bus.O_ACTIVE   = (state_q == ST_RUN);

endmodule

// File: tb/tb_enc_cnt_mc.sv
// Directed bench for enc_cnt_mc: an 8-bit wrapping instance and an 8-bit
// saturating instance share the same stimulus.
module tb_enc_cnt_mc;
  localparam int W  = 8;
  localparam int CH = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  enc_cnt_mc_if #(.P_CNT_W(W), .P_CH(CH)) wif ();
  enc_cnt_mc_if #(.P_CNT_W(W), .P_CH(CH)) sif ();

  assign sif.I_ARM = wif.I_ARM;
  assign sif.I_Z   = wif.I_Z;
  assign sif.I_A   = wif.I_A;
  assign sif.I_ACK = wif.I_ACK;

  enc_cnt_mc #(.P_CNT_W(W), .P_CH(CH), .P_SYNC(2), .P_WRAP(1)) dut_wrap (
    .CLK   (clk),
    .I_RST (rst),
    .bus   (wif)
  );

  enc_cnt_mc #(.P_CNT_W(W), .P_CH(CH), .P_SYNC(2), .P_WRAP(0)) dut_sat (
    .CLK   (clk),
    .I_RST (rst),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("check %s got=%0d ok", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_clear(input string tag);
    chk({tag, "_w_active"}, 64'(wif.O_ACTIVE),   64'd0);
    chk({tag, "_w_time"},   64'(wif.O_TIME),     64'd0);
    chk({tag, "_w_valid"},  64'(wif.O_VALID),    64'd0);
    chk({tag, "_w_lost"},   64'(wif.O_LOST),     64'd0);
    chk({tag, "_w_ovf"},    64'(wif.O_OVERFLOW), 64'd0);
    chk({tag, "_w_cnt"},    64'(wif.O_CNT),      64'd0);
    chk({tag, "_s_active"}, 64'(sif.O_ACTIVE),   64'd0);
    chk({tag, "_s_time"},   64'(sif.O_TIME),     64'd0);
    chk({tag, "_s_valid"},  64'(sif.O_VALID),    64'd0);
    chk({tag, "_s_lost"},   64'(sif.O_LOST),     64'd0);
    chk({tag, "_s_ovf"},    64'(sif.O_OVERFLOW), 64'd0);
    chk({tag, "_s_cnt"},    64'(sif.O_CNT),      64'd0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    wif.I_ARM = 1'b0;
    wif.I_Z   = 1'b0;
    wif.I_A   = '0;
    wif.I_ACK = '0;
    tick();
    tick();
    chk_clear("reset");

    // Arm, toggle A[3] while waiting for Z: must be ignored.
    rst = 1'b0;
    wif.I_ARM = 1'b1;
    tick();
    wif.I_A = 4'b1000;
    tick(); tick(); tick();
    wif.I_A = 4'b0000;
    tick(); tick();
    chk("waitz_active", 64'(wif.O_ACTIVE), 64'd0);
    chk("waitz_valid",  64'(wif.O_VALID),  64'd0);
    chk("waitz_lost",   64'(wif.O_LOST),   64'd0);

    // Z rises at edge 0; RUN after edge 2.
    wif.I_Z = 1'b1;
    tick(); tick();
    chk("start_e1_active", 64'(wif.O_ACTIVE), 64'd0);
    tick();
    chk("start_e2_active", 64'(wif.O_ACTIVE), 64'd1);
    chk("start_time0",     64'(wif.O_TIME),   64'd0);
    tick(); chk("start_time1", 64'(wif.O_TIME), 64'd1);
    tick(); chk("start_time2", 64'(wif.O_TIME), 64'd2);
    tick(); chk("start_time3", 64'(wif.O_TIME), 64'd3);

    // Capture on ch1 raised at O_TIME=9.
    repeat (6) tick();
    chk("time9", 64'(wif.O_TIME), 64'd9);
    wif.I_A = 4'b0010;
    tick(); tick(); tick();
    chk("cap1_cnt",   64'(wif.O_CNT[1*W +: W]), 64'd11);
    chk("cap1_valid", 64'(wif.O_VALID),         64'b0010);
    chk("cap1_time",  64'(wif.O_TIME),          64'd12);
    wif.I_ACK = 4'b0010;
    tick();
    wif.I_ACK = 4'b0000;
    wif.I_A   = 4'b0000;
    chk("ack1_valid", 64'(wif.O_VALID),         64'd0);
    chk("ack1_cnt",   64'(wif.O_CNT[1*W +: W]), 64'd11);

    // Lost sample on ch0.
    wif.I_A = 4'b0001;
    tick(); tick(); tick();
    chk("cap0_cnt",   64'(wif.O_CNT[0*W +: W]), 64'd15);
    chk("cap0_valid", 64'(wif.O_VALID),         64'b0001);
    wif.I_A = 4'b0000;
    repeat (5) tick();
    wif.I_A = 4'b0001;
    tick(); tick(); tick();
    chk("lost0_cnt",   64'(wif.O_CNT[0*W +: W]), 64'd15);
    chk("lost0_lost",  64'(wif.O_LOST),          64'b0001);
    chk("lost0_valid", 64'(wif.O_VALID),         64'b0001);
    wif.I_A = 4'b0000;

    // Ch2: second edge acked on the capture edge reloads without loss.
    wif.I_A = 4'b0100;
    tick(); tick(); tick();
    chk("cap2_cnt", 64'(wif.O_CNT[2*W +: W]), 64'd26);
    wif.I_A = 4'b0000;
    repeat (4) tick();
    wif.I_A = 4'b0100;
    tick(); tick();
    wif.I_ACK = 4'b0100;
    tick();
    wif.I_ACK = 4'b0000;
    wif.I_A   = 4'b0000;
    chk("reload2_cnt",   64'(wif.O_CNT[2*W +: W]), 64'd33);
    chk("reload2_valid", 64'(wif.O_VALID),         64'b0101);
    chk("reload2_lost",  64'(wif.O_LOST),          64'b0001);

    // Clear all, then simultaneous edges on all four channels.
    wif.I_ACK = 4'b1111;
    tick();
    wif.I_ACK = 4'b0000;
    chk("ackall_valid", 64'(wif.O_VALID), 64'd0);
    tick(); tick();
    wif.I_A = 4'b1111;
    tick(); tick(); tick();
    for (int n = 0; n < CH; n++)
      chk($sformatf("simul_cnt%0d", n), 64'(wif.O_CNT[n*W +: W]), 64'd39);
    chk("simul_valid", 64'(wif.O_VALID), 64'b1111);
    chk("simul_lost",  64'(wif.O_LOST),  64'b0001);
    wif.I_A = 4'b0000;

    // Wrap versus saturate at 8 bits.
    repeat (215) tick();
    chk("pre_w_time", 64'(wif.O_TIME),     64'd255);
    chk("pre_w_ovf",  64'(wif.O_OVERFLOW), 64'd0);
    chk("pre_s_time", 64'(sif.O_TIME),     64'd255);
    chk("pre_s_ovf",  64'(sif.O_OVERFLOW), 64'd0);
    tick();
    chk("wrap_time",  64'(wif.O_TIME),     64'd0);
    chk("wrap_ovf",   64'(wif.O_OVERFLOW), 64'd1);
    chk("sat_time",   64'(sif.O_TIME),     64'd255);
    chk("sat_ovf",    64'(sif.O_OVERFLOW), 64'd1);
    tick();
    chk("wrap_time1", 64'(wif.O_TIME),     64'd1);
    chk("wrap_ovf1",  64'(wif.O_OVERFLOW), 64'd1);
    chk("sat_time1",  64'(sif.O_TIME),     64'd255);

    // One-cycle disarm clears everything.
    wif.I_ARM = 1'b0;
    tick();
    wif.I_ARM = 1'b1;
    chk_clear("disarm");

    // Re-arm with Z still high: needs a fresh Z rising edge.
    tick();
    repeat (4) tick();
    chk("rearm_zhigh_active", 64'(wif.O_ACTIVE), 64'd0);
    wif.I_Z = 1'b0;
    tick(); tick(); tick();
    wif.I_Z = 1'b1;
    tick(); tick();
    chk("rearm_e1_active", 64'(wif.O_ACTIVE), 64'd0);
    tick();
    chk("rearm_e2_active", 64'(wif.O_ACTIVE), 64'd1);
    chk("rearm_time0",     64'(wif.O_TIME),   64'd0);
    wif.I_A = 4'b0010;
    tick(); tick(); tick();
    chk("rearm_cap_cnt",   64'(wif.O_CNT[1*W +: W]), 64'd2);
    chk("rearm_cap_valid", 64'(wif.O_VALID),         64'b0010);
    chk("rearm_time3",     64'(wif.O_TIME),          64'd3);
    wif.I_A = 4'b0000;

    // Reset in RUN.
    rst = 1'b1;
    tick();
    chk_clear("runrst");
    rst = 1'b0;
    tick();
    chk("post_rst_active", 64'(wif.O_ACTIVE), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
